// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode/funct
// constants, ALU operation encodings, FSM states and datapath select codes.
package multicycle_control_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation encodings, shared with the datapath ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLT  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  // pc_src select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // alu_src_b select
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  // Shifts take their amount from shamt, routed through the immediate port
  function automatic logic isShiftFunct(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational opcode/funct decode to ALU operation, shift flag and an
// illegal-encoding flag for the multi-cycle control FSM.
module alu_decode
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               isShift,
  output logic               illegal
);

  logic [3:0] code;

  always_comb begin
    code    = ALU_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  code = ALU_SLL;
          FN_SRL:  code = ALU_SRL;
          FN_SRA:  code = ALU_SRA;
          FN_ADD:  code = ALU_ADD;
          FN_ADDU: code = ALU_ADDU;
          FN_SUB:  code = ALU_SUB;
          FN_SUBU: code = ALU_SUBU;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_SLT:  code = ALU_SLT;
          FN_SLTU: code = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI:      code = ALU_ADD;
      OP_ADDIU:     code = ALU_ADDU;
      OP_SLTI:      code = ALU_SLT;
      OP_SLTIU:     code = ALU_SLTU;
      OP_ANDI:      code = ALU_AND;
      OP_ORI:       code = ALU_OR;
      OP_XORI:      code = ALU_XOR;
      OP_LW, OP_SW: code = ALU_ADD;
      OP_BEQ, OP_BNE: code = ALU_SUB;
      OP_J:         code = ALU_NOP;
      default:      illegal = 1'b1;
    endcase
  end

  assign aluOp   = ALUOP_W'(code);
  assign isShift = (opcode == OP_RTYPE) && isShiftFunct(funct);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Define MULTICYCLE_CONTROL_TRAP_EN to trap illegal encodings.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               instr_done,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [ALUOP_W-1:0] ADD_OP = ALUOP_W'(ALU_ADD);
  localparam logic [ALUOP_W-1:0] SUB_OP = ALUOP_W'(ALU_SUB);

  state_t             stateReg;
  state_t             stateNext;
  logic [CNT_W-1:0]   retiredReg;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [ALUOP_W-1:0] decAluOp;
  logic               decShift;
  logic               decIllegal;
  logic               isRType;
  logic               isImm;
  logic               isMem;
  logic               isBranch;
  logic               unusedInstrBits;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign unusedInstrBits = ^instr[25:6];

  alu_decode #(
    .ALUOP_W (ALUOP_W)
  ) uAluDecode (
    .opcode  (opcode),
    .funct   (funct),
    .aluOp   (decAluOp),
    .isShift (decShift),
    .illegal (decIllegal)
  );

  assign isRType  = (opcode == OP_RTYPE);
  assign isImm    = opcode inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                                   OP_XORI, OP_SLTI, OP_SLTIU};
  assign isMem    = (opcode == OP_LW) || (opcode == OP_SW);
  assign isBranch = (opcode == OP_BEQ) || (opcode == OP_BNE);

  // Outputs decode straight from state; reset forces every strobe low,
  // which also abandons any memory request in flight.
  always_comb begin
    stateNext  = stateReg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = '0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    if (!rst) begin
      case (stateReg)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ADD_OP;
            pc_src    = PC_SRC_ALU;
            stateNext = S_DECODE;
          end
        end
        S_DECODE: begin
          // Speculatively compute the branch target into ALUOut
          alu_src_b = SRCB_IMM_SH;
          alu_op    = ADD_OP;
          if (decIllegal) begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            stateNext = S_TRAP;
`else
            stateNext  = S_FETCH;
            instr_done = 1'b1;
`endif
          end else if (isRType) begin
            stateNext = S_EXEC_R;
          end else if (isImm) begin
            stateNext = S_EXEC_I;
          end else if (isMem) begin
            stateNext = S_MEM_ADDR;
          end else if (isBranch) begin
            stateNext = S_BRANCH;
          end else begin
            stateNext = S_JUMP;
          end
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = decShift ? SRCB_IMM : SRCB_RT;
          alu_op    = decAluOp;
          stateNext = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = decAluOp;
          stateNext = S_WB_ALU;
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          reg_dst    = isRType;
          alu_op     = decAluOp;
          instr_done = 1'b1;
          stateNext  = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ADD_OP;
          stateNext = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            stateNext = S_WB_MEM;
          end
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          stateNext  = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            stateNext  = S_FETCH;
          end
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_RT;
          alu_op     = SUB_OP;
          pc_src     = PC_SRC_ALUOUT;
          pc_write   = (opcode == OP_BNE) ? !zero : zero;
          instr_done = 1'b1;
          stateNext  = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_JUMP;
          instr_done = 1'b1;
          stateNext  = S_FETCH;
        end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        S_TRAP: begin
          stateNext = S_TRAP;
        end
`endif
        default: begin
          stateNext = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= S_FETCH;
      retiredReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (instr_done) begin
        retiredReg <= retiredReg + CNT_W'(1);
      end
    end
  end

  assign retired = retiredReg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues hand-computed
// per-cycle control vectors, a negedge monitor pops and compares them.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int CW = 4;
  localparam int A_ADD = int'(ALU_ADD);
  localparam int A_SUB = int'(ALU_SUB);
  localparam int A_OR  = int'(ALU_OR);
  localparam int A_SLL = int'(ALU_SLL);

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]    pc_src;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [3:0]    alu_op;
  logic          reg_dst, reg_write, mem_to_reg, instr_done;
  logic [CW-1:0] retired;

  multicycle_control #(
    .ALUOP_W (4),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          memReq, memWe, iord, irWrite, pcWrite;
    logic [1:0]    pcSrc;
    logic          aluSrcA;
    logic [1:0]    aluSrcB;
    logic [3:0]    aluOp;
    logic          regDst, regWrite, memToReg, instrDone;
    logic [CW-1:0] retired;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    string tag;
  } exp_t;

  exp_t           expQ[$];
  exp_t           cur;
  ctl_t           act;
  logic [21:0]    actBits, expBits;
  logic [CW-1:0]  expRet;
  int             nChecks = 0;
  int             nFails  = 0;
  ctl_t           fRdy, fWait, dec, zeroV, jEx, maV;

  // Field order: memReq memWe iord irWrite pcWrite pcSrc aluSrcA aluSrcB aluOp regDst regWrite memToReg instrDone
  function automatic ctl_t cv(input int mreq, mwe, io, irw, pcw, psrc, sa, sb, op, rd, rw, m2r, dn);
    ctl_t v;
    v.memReq = 1'(mreq);  v.memWe = 1'(mwe);   v.iord = 1'(io);
    v.irWrite = 1'(irw);  v.pcWrite = 1'(pcw); v.pcSrc = 2'(psrc);
    v.aluSrcA = 1'(sa);   v.aluSrcB = 2'(sb);  v.aluOp = 4'(op);
    v.regDst = 1'(rd);    v.regWrite = 1'(rw); v.memToReg = 1'(m2r);
    v.instrDone = 1'(dn); v.retired = '0;
    return v;
  endfunction

  task automatic push(input ctl_t v, input string tag);
    exp_t e;
    e.v = v;
    e.v.retired = expRet;
    e.tag = tag;
    expQ.push_back(e);
    if (v.instrDone) expRet++;
  endtask

  task automatic cyc(input logic rdy);
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic runBranch(input logic [31:0] ins, input logic z, input int pcw, input string tag);
    instr = ins;
    zero  = z;
    push(fRdy, {tag, " fetch"});
    push(dec, {tag, " decode"});
    push(cv(0, 0, 0, 0, pcw, 1, 1, 0, A_SUB, 0, 0, 0, 1), tag);
    repeat (3) cyc(1'b1);
  endtask

  task automatic runJump(input string tag);
    instr = 32'h08000010;
    zero  = 1'b0;
    push(fRdy, {tag, " fetch"});
    push(dec, {tag, " decode"});
    push(jEx, tag);
    repeat (3) cyc(1'b1);
  endtask

  task automatic runAdd(input string tag);
    instr = 32'h00221820;
    zero  = 1'b1;
    push(fRdy, {tag, " fetch"});
    push(dec, {tag, " decode"});
    push(cv(0, 0, 0, 0, 0, 0, 1, 0, A_ADD, 0, 0, 0, 0), {tag, " exec"});
    push(cv(0, 0, 0, 0, 0, 0, 0, 0, A_ADD, 1, 1, 0, 1), tag);
    repeat (4) cyc(1'b1);
  endtask

  // Monitor: one comparison per queued cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
      act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
             alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg, instr_done, retired};
      actBits = act;
      expBits = cur.v;
      nChecks++;
      if (actBits !== expBits) begin
        nFails++;
        $display("FAIL %s: got %b required %b", cur.tag, actBits, expBits);
      end else if (cur.v.instrDone) begin
        $display("retire %s: retired=%0d", cur.tag, act.retired);
      end
    end
  end

  initial begin
    fRdy  = cv(1, 0, 0, 1, 1, 0, 0, 1, A_ADD, 0, 0, 0, 0);
    fWait = cv(1, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0);
    dec   = cv(0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0, 0);
    maV   = cv(0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 0, 0, 0);
    jEx   = cv(0, 0, 0, 0, 1, 2, 0, 0, A_ADD, 0, 0, 0, 1);
    zeroV = '0;
    rst = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b1; expRet = '0;
    @(posedge clk);
    #1;
    // Reset with mem_ready high: everything, including mem_req, must be low
    push(zeroV, "reset");
    cyc(1'b1);
    rst = 1'b0;

    runAdd("add");

    // lw with three wait cycles in MEM_RD
    instr = 32'h8C220008;
    push(fRdy, "lw fetch");
    push(dec, "lw decode");
    push(maV, "lw addr");
    repeat (4) push(cv(1, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0), "lw memrd");
    push(cv(0, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 1, 1, 1), "lw");
    repeat (3) cyc(1'b1);
    repeat (3) cyc(1'b0);
    repeat (2) cyc(1'b1);

    // beq taken, with one fetch wait cycle ahead of it
    push(fWait, "beq fetch wait");
    mem_ready = 1'b0;
    instr = 32'h10220003;
    zero = 1'b1;
    cyc(1'b0);
    runBranch(32'h10220003, 1'b1, 1, "beq taken");
    runBranch(32'h10220003, 1'b0, 0, "beq not taken");
    runBranch(32'h14220003, 1'b1, 0, "bne not taken");
    runBranch(32'h14220003, 1'b0, 1, "bne taken");

    // sll $2,$1,4
    instr = 32'h00011100;
    push(fRdy, "sll fetch");
    push(dec, "sll decode");
    push(cv(0, 0, 0, 0, 0, 0, 1, 2, A_SLL, 0, 0, 0, 0), "sll exec");
    push(cv(0, 0, 0, 0, 0, 0, 0, 0, A_SLL, 1, 1, 0, 1), "sll");
    repeat (4) cyc(1'b1);

    // ori $2,$1,5
    instr = 32'h34220005;
    push(fRdy, "ori fetch");
    push(dec, "ori decode");
    push(cv(0, 0, 0, 0, 0, 0, 1, 2, A_OR, 0, 0, 0, 0), "ori exec");
    push(cv(0, 0, 0, 0, 0, 0, 0, 0, A_OR, 0, 1, 0, 1), "ori");
    repeat (4) cyc(1'b1);

    // sw with two wait cycles in MEM_WR
    instr = 32'hAC220004;
    push(fRdy, "sw fetch");
    push(dec, "sw decode");
    push(maV, "sw addr");
    repeat (2) push(cv(1, 1, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0), "sw memwr");
    push(cv(1, 1, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 1), "sw");
    repeat (3) cyc(1'b1);
    repeat (2) cyc(1'b0);
    cyc(1'b1);

    runJump("j");

    // Reset in the middle of a stalled lw read
    instr = 32'h8C220008;
    push(fRdy, "lw2 fetch");
    push(dec, "lw2 decode");
    push(maV, "lw2 addr");
    repeat (2) push(cv(1, 0, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0), "lw2 memrd");
    repeat (3) cyc(1'b1);
    repeat (2) cyc(1'b0);
    rst = 1'b1;
    expRet = '0;
    push(zeroV, "reset mid-read");
    cyc(1'b1);
    rst = 1'b0;
    runAdd("add after reset");

    // Illegal opcode 0x3F
    instr = 32'hFC000000;
    zero = 1'b0;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    push(fRdy, "illegal fetch");
    push(dec, "illegal decode");
    repeat (2) push(zeroV, "trap");
    repeat (4) cyc(1'b1);
    rst = 1'b1;
    expRet = '0;
    push(zeroV, "reset from trap");
    cyc(1'b1);
    rst = 1'b0;
`else
    push(fRdy, "illegal fetch");
    push(cv(0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0, 0, 1), "illegal as nop");
    repeat (2) cyc(1'b1);
`endif

    // Enough jumps to carry the narrow counter through all-ones back to 0
    for (int i = 0; i < 18; i++) runJump($sformatf("j wrap %0d", i));

    cyc(1'b1);
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("FAIL scoreboard drain: got %0d entries left, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
